wshb_arbiter_qos: RTL and testbench

WSHB_ARBITER_QOS -- requirements
Module: wshb_arbiter_qos

---
 rtl/wshb_arb_pkg.sv | 21 ++
 rtl/wshb_if.sv | 15 +
 rtl/wshb_arb_mux.sv | 55 +++++
 rtl/wshb_arbiter_qos.sv | 131 +++++++++++++
 tb/tb_wshb_arbiter_qos.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master Wishbone QoS arbiter: FSM state and master index.
package wshb_arb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_MIRE = 2'd1,
    GNT_VGA  = 2'd2,
    SWITCH   = 2'd3
  } arb_state_t;

  // Also the bit position of each master inside the one-hot grant.
  typedef enum logic {
    MST_MIRE = 1'b0,
    MST_VGA  = 1'b1
  } mst_idx_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered bus bundle, 32-bit address and data.
interface wshb_if;
  logic [wshb_arb_pkg::WB_AW-1:0] adr;
  logic [wshb_arb_pkg::WB_DW-1:0] dat_ms;
  logic [wshb_arb_pkg::WB_DW-1:0] dat_sm;
  logic [wshb_arb_pkg::WB_SW-1:0] sel;
  logic [2:0]                     cti;
  logic [1:0]                     bte;
  logic                           we, cyc, stb, ack, err, rty;

  modport master (output adr, dat_ms, sel, cti, bte, we, cyc, stb,
                  input  dat_sm, ack, err, rty);
  modport slave  (input  adr, dat_ms, sel, cti, bte, we, cyc, stb,
                  output dat_sm, ack, err, rty);
endinterface

// File: rtl/wshb_arb_mux.sv
// Grant-driven routing between the VGA / mire masters and the SDRAM port.
// A zero grant parks the SDRAM side (cyc/stb low) and silences both masters.
module wshb_arb_mux import wshb_arb_pkg::*; (
  input  logic [1:0] grant,
  wshb_if.slave      s_vga,
  wshb_if.slave      s_mire,
  wshb_if.master     m_sdram
);

  logic sel_vga, sel_mire;
  assign sel_vga  = grant[MST_VGA];
  assign sel_mire = grant[MST_MIRE];

  // Forward path: granted master drives the SDRAM request, otherwise all zero.
  always_comb begin
    m_sdram.adr    = '0;
    m_sdram.dat_ms = '0;
    m_sdram.sel    = '0;
    m_sdram.cti    = '0;
    m_sdram.bte    = '0;
    m_sdram.we     = 1'b0;
    m_sdram.cyc    = 1'b0;
    m_sdram.stb    = 1'b0;
    if (sel_vga) begin
      m_sdram.adr    = s_vga.adr;
      m_sdram.dat_ms = s_vga.dat_ms;
      m_sdram.sel    = s_vga.sel;
      m_sdram.cti    = s_vga.cti;
      m_sdram.bte    = s_vga.bte;
      m_sdram.we     = s_vga.we;
      m_sdram.cyc    = s_vga.cyc;
      m_sdram.stb    = s_vga.stb;
    end else if (sel_mire) begin
      m_sdram.adr    = s_mire.adr;
      m_sdram.dat_ms = s_mire.dat_ms;
      m_sdram.sel    = s_mire.sel;
      m_sdram.cti    = s_mire.cti;
      m_sdram.bte    = s_mire.bte;
      m_sdram.we     = s_mire.we;
      m_sdram.cyc    = s_mire.cyc;
      m_sdram.stb    = s_mire.stb;
    end
  end

  // Return path: only the granted master ever sees a response or read data.
  assign s_vga.ack     = sel_vga  & m_sdram.ack;
  assign s_vga.err     = sel_vga  & m_sdram.err;
  assign s_vga.rty     = sel_vga  & m_sdram.rty;
  assign s_vga.dat_sm  = sel_vga  ? m_sdram.dat_sm : '0;
  assign s_mire.ack    = sel_mire & m_sdram.ack;
  assign s_mire.err    = sel_mire & m_sdram.err;
  assign s_mire.rty    = sel_mire & m_sdram.rty;
  assign s_mire.dat_sm = sel_mire ? m_sdram.dat_sm : '0;

endmodule

// File: rtl/wshb_arbiter_qos.sv
// Two-master Wishbone arbiter (VGA reader vs. mire pattern writer) onto SDRAM.
// VGA wins ties; each grant is capped at QUOTA transfers while the other master
// waits; an urgent VGA (FIFO low) preempts mire at the next transfer boundary.
// A one-cycle SWITCH bubble separates every handover.
// Optional: define WSHB_ARB_STATS_EN for 32-bit per-master transfer counters.
module wshb_arbiter_qos import wshb_arb_pkg::*; #(
  parameter int QUOTA = 16,
  parameter int HDISP = 800,
  parameter int VDISP = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_urgent,
  output logic [1:0]  grant,
  output logic [31:0] cnt_vga,
  output logic [31:0] cnt_mire,
  wshb_if.slave       wshb_ifs_vga,
  wshb_if.slave       wshb_ifs_mire,
  wshb_if.master      wshb_ifm_sdram
);

  localparam int            CW      = $clog2(QUOTA + 1);
  localparam logic [CW-1:0] QUOTA_C = CW'(QUOTA);

  if (QUOTA < 1 || HDISP < 1 || VDISP < 1) begin : g_cfg_err
    $error("wshb_arbiter_qos: QUOTA, HDISP and VDISP must be positive");
  end

  arb_state_t    state_q, state_d;
  mst_idx_t      last_q, last_d;
  logic [CW-1:0] xfer_cnt_q, xfer_cnt_d, cnt_inc;
  logic          term, quota_hit, vga_cyc, mire_cyc, mire_stb;

  assign vga_cyc  = wshb_ifs_vga.cyc;
  assign mire_cyc = wshb_ifs_mire.cyc;
  assign mire_stb = wshb_ifs_mire.stb;

  // sdram stb is already gated by the grant, so term is 0 in IDLE/SWITCH.
  assign term      = wshb_ifm_sdram.stb &
                     (wshb_ifm_sdram.ack | wshb_ifm_sdram.err | wshb_ifm_sdram.rty);
  assign cnt_inc   = (term && xfer_cnt_q != QUOTA_C) ? xfer_cnt_q + CW'(1) : xfer_cnt_q;
  // Uses the post-increment count so the switch lands right after the last transfer.
  assign quota_hit = (cnt_inc == QUOTA_C);

  // One-hot grant decoded from the registered state.
  always_comb begin
    grant = 2'b00;
    if (state_q == GNT_VGA)  grant[MST_VGA]  = 1'b1;
    if (state_q == GNT_MIRE) grant[MST_MIRE] = 1'b1;
  end

  // Next state; cyc-drop checks come first so they win over quota/preemption.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (vga_cyc)       state_d = GNT_VGA;
        else if (mire_cyc) state_d = GNT_MIRE;
      end
      GNT_VGA: begin
        last_d = MST_VGA;
        if (!vga_cyc)                  state_d = mire_cyc ? SWITCH : IDLE;
        else if (mire_cyc && quota_hit) state_d = SWITCH;
      end
      GNT_MIRE: begin
        last_d = MST_MIRE;
        if (!mire_cyc)                                        state_d = vga_cyc ? SWITCH : IDLE;
        else if (vga_cyc && vga_urgent && (term || !mire_stb)) state_d = SWITCH;
        else if (vga_cyc && quota_hit)                        state_d = SWITCH;
      end
      SWITCH:  state_d = (last_q == MST_VGA) ? GNT_MIRE : GNT_VGA;
      default: state_d = IDLE;
    endcase
  end

  // Transfer counter restarts on every fresh grant.
  always_comb begin
    xfer_cnt_d = cnt_inc;
    if ((state_d == GNT_VGA || state_d == GNT_MIRE) && state_d != state_q)
      xfer_cnt_d = '0;
  end

  // FSM and quota counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= MST_MIRE;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  wshb_arb_mux u_mux (
    .grant   (grant),
    .s_vga   (wshb_ifs_vga),
    .s_mire  (wshb_ifs_mire),
    .m_sdram (wshb_ifm_sdram)
  );

`ifdef WSHB_ARB_STATS_EN
  logic [31:0] cnt_vga_q, cnt_vga_d, cnt_mire_q, cnt_mire_d;

  // Free-running, wrapping count of terminated transfers per master.
  always_comb begin
    cnt_vga_d  = cnt_vga_q  + ((term && grant[MST_VGA])  ? 32'd1 : 32'd0);
    cnt_mire_d = cnt_mire_q + ((term && grant[MST_MIRE]) ? 32'd1 : 32'd0);
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_vga_q  <= '0;
      cnt_mire_q <= '0;
    end else begin
      cnt_vga_q  <= cnt_vga_d;
      cnt_mire_q <= cnt_mire_d;
    end
  end

  assign cnt_vga  = cnt_vga_q;
  assign cnt_mire = cnt_mire_q;
`else
  assign cnt_vga  = '0;
  assign cnt_mire = '0;
`endif

endmodule

// File: tb/tb_wshb_arbiter_qos.sv
// Directed bench for wshb_arbiter_qos: one DUT at QUOTA=4, one at QUOTA=16,
// both fed the same master stimulus, each with a zero-wait SDRAM model.
module tb_wshb_arbiter_qos;

  localparam logic [31:0] MB = 32'h0000_1000;  // mire base address
  localparam logic [31:0] VB = 32'h0000_8000;  // vga base address
`ifdef WSHB_ARB_STATS_EN
  localparam logic [31:0] EXP_V = 32'd7;
  localparam logic [31:0] EXP_M = 32'd3;
`else
  localparam logic [31:0] EXP_V = 32'd0;
  localparam logic [31:0] EXP_M = 32'd0;
`endif

  logic        clk, rst_n, vga_urgent, sd_ack_en;
  logic        vga_cyc, vga_stb, mire_cyc, mire_stb;
  logic [31:0] vga_adr, mire_adr;
  logic [1:0]  grant, grant16;
  logic [31:0] cnt_vga, cnt_mire, cnt_vga16, cnt_mire16;
  int          checks, errors;

  wshb_if if_vga(), if_mire(), if_sd();
  wshb_if if_vga16(), if_mire16(), if_sd16();

  assign if_vga.adr = vga_adr;     assign if_vga16.adr = vga_adr;
  assign if_vga.dat_ms = '0;       assign if_vga16.dat_ms = '0;
  assign if_vga.sel = 4'hf;        assign if_vga16.sel = 4'hf;
  assign if_vga.cti = '0;          assign if_vga16.cti = '0;
  assign if_vga.bte = '0;          assign if_vga16.bte = '0;
  assign if_vga.we = 1'b0;         assign if_vga16.we = 1'b0;
  assign if_vga.cyc = vga_cyc;     assign if_vga16.cyc = vga_cyc;
  assign if_vga.stb = vga_stb;     assign if_vga16.stb = vga_stb;
  assign if_mire.adr = mire_adr;   assign if_mire16.adr = mire_adr;
  assign if_mire.dat_ms = ~mire_adr; assign if_mire16.dat_ms = ~mire_adr;
  assign if_mire.sel = 4'hf;       assign if_mire16.sel = 4'hf;
  assign if_mire.cti = '0;         assign if_mire16.cti = '0;
  assign if_mire.bte = '0;         assign if_mire16.bte = '0;
  assign if_mire.we = 1'b1;        assign if_mire16.we = 1'b1;
  assign if_mire.cyc = mire_cyc;   assign if_mire16.cyc = mire_cyc;
  assign if_mire.stb = mire_stb;   assign if_mire16.stb = mire_stb;

  // Zero-wait SDRAM models; read data is the inverted address.
  assign if_sd.ack = if_sd.cyc & if_sd.stb & sd_ack_en;
  assign if_sd.err = 1'b0;
  assign if_sd.rty = 1'b0;
  assign if_sd.dat_sm = ~if_sd.adr;
  assign if_sd16.ack = if_sd16.cyc & if_sd16.stb & sd_ack_en;
  assign if_sd16.err = 1'b0;
  assign if_sd16.rty = 1'b0;
  assign if_sd16.dat_sm = ~if_sd16.adr;

  wshb_arbiter_qos #(.QUOTA(4)) dut (
    .clk(clk), .rst_n(rst_n), .vga_urgent(vga_urgent), .grant(grant),
    .cnt_vga(cnt_vga), .cnt_mire(cnt_mire),
    .wshb_ifs_vga(if_vga), .wshb_ifs_mire(if_mire), .wshb_ifm_sdram(if_sd));

  wshb_arbiter_qos #(.QUOTA(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .vga_urgent(vga_urgent), .grant(grant16),
    .cnt_vga(cnt_vga16), .cnt_mire(cnt_mire16),
    .wshb_ifs_vga(if_vga16), .wshb_ifs_mire(if_mire16), .wshb_ifm_sdram(if_sd16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic idle_masters;
    vga_cyc = 0; vga_stb = 0; vga_adr = VB; vga_urgent = 0;
    mire_cyc = 0; mire_stb = 0; mire_adr = MB;
  endtask

  // Leaves the bench just after a clock edge with rst_n released, FSM in IDLE.
  task automatic do_reset;
    rst_n = 0; idle_masters(); sd_ack_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic test_reset;
    rst_n = 0; idle_masters(); sd_ack_en = 1;
    mire_cyc = 1; mire_stb = 1;  // request held during reset must not be granted
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got=%b exp=00", grant); end
    checks++; if (if_sd.cyc !== 1'b0 || if_sd.stb !== 1'b0) begin errors++; $display("FAIL rst_sd_cyc got=%b%b exp=00", if_sd.cyc, if_sd.stb); end
    checks++; if (cnt_vga !== 32'd0 || cnt_mire !== 32'd0) begin errors++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", cnt_vga, cnt_mire); end
    checks++; if (dut.xfer_cnt_q !== '0) begin errors++; $display("FAIL rst_xfer_cnt got=%0d exp=0", dut.xfer_cnt_q); end
    do_reset();
  endtask

  task automatic test_both_req;
    do_reset(); sd_ack_en = 0;
    vga_cyc = 1; vga_stb = 1; vga_adr = 32'h100;
    mire_cyc = 1; mire_stb = 1; mire_adr = 32'h200;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL both_latency got=%b exp=00", grant); end
    @(negedge clk);
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL both_grant got=%b exp=10", grant); end
    checks++; if (if_mire.ack !== 1'b0 || if_vga.ack !== 1'b0) begin errors++; $display("FAIL both_noack got=%b%b exp=00", if_vga.ack, if_mire.ack); end
    checks++; if (if_sd.adr !== 32'h100 || if_sd.cyc !== 1'b1) begin errors++; $display("FAIL both_route got=%h/%b exp=100/1", if_sd.adr, if_sd.cyc); end
    @(posedge clk); #1 sd_ack_en = 1;
    @(negedge clk);
    checks++; if (if_vga.ack !== 1'b1 || if_mire.ack !== 1'b0) begin errors++; $display("FAIL both_ack got=%b%b exp=10", if_vga.ack, if_mire.ack); end
    checks++; if (if_mire.dat_sm !== 32'h0) begin errors++; $display("FAIL both_mire_dat got=%h exp=0", if_mire.dat_sm); end
    checks++; if (if_vga.dat_sm !== ~32'h100) begin errors++; $display("FAIL both_vga_dat got=%h exp=%h", if_vga.dat_sm, ~32'h100); end
  endtask

  task automatic test_quota;
    int mire_n, acks_first, sw, phase, bad_adr;
    logic [31:0] exp_adr;
    do_reset(); sd_ack_en = 1;
    mire_cyc = 1; mire_stb = 1; mire_adr = MB;
    mire_n = 0; acks_first = 0; sw = 0; phase = 0; bad_adr = 0;
    @(negedge clk);
    @(posedge clk); #1 vga_cyc = 1; vga_stb = 1; vga_adr = VB;
    for (int c = 0; c < 60 && mire_n < 10; c++) begin
      @(negedge clk);
      if (grant == 2'b01 && if_mire.ack) begin
        exp_adr = MB + 32'(mire_n);
        if (if_sd.adr !== exp_adr) bad_adr++;
        mire_n++;
        if (phase == 0) acks_first++;
      end
      if (phase == 0 && grant == 2'b00 && acks_first > 0) sw++;
      if (phase == 0 && grant == 2'b10) phase = 1;
      @(posedge clk); #1;
      mire_adr = MB + 32'(mire_n);
      if (mire_n == 10) begin mire_cyc = 0; mire_stb = 0; end
    end
    vga_cyc = 0; vga_stb = 0;
    checks++; if (acks_first !== 4) begin errors++; $display("FAIL quota_acks got=%0d exp=4", acks_first); end
    checks++; if (sw !== 1) begin errors++; $display("FAIL quota_switch_len got=%0d exp=1", sw); end
    checks++; if (phase !== 1) begin errors++; $display("FAIL quota_to_vga got=%0d exp=1", phase); end
    checks++; if (mire_n !== 10) begin errors++; $display("FAIL quota_total got=%0d exp=10", mire_n); end
    checks++; if (bad_adr !== 0) begin errors++; $display("FAIL quota_adr_seq got=%0d exp=0", bad_adr); end
  endtask

  task automatic test_mire_alone;
    int n, acks16, granted, held_bad, held_bad4;
    do_reset(); sd_ack_en = 1;
    mire_cyc = 1; mire_stb = 1; mire_adr = MB;
    n = 0; acks16 = 0; granted = 0; held_bad = 0; held_bad4 = 0;
    for (int c = 0; c < 80 && n < 40; c++) begin
      @(negedge clk);
      if (grant16 == 2'b01) granted = 1; else if (granted != 0) held_bad++;
      if (granted != 0 && grant != 2'b01) held_bad4++;
      if (if_mire16.ack) acks16++;
      if (if_mire.ack) n++;
      @(posedge clk); #1;
      mire_adr = MB + 32'(n);
      if (n == 40) begin mire_cyc = 0; mire_stb = 0; end
    end
    checks++; if (acks16 !== 40) begin errors++; $display("FAIL alone_acks16 got=%0d exp=40", acks16); end
    checks++; if (held_bad !== 0) begin errors++; $display("FAIL alone_held16 got=%0d exp=0", held_bad); end
    checks++; if (held_bad4 !== 0) begin errors++; $display("FAIL alone_held4 got=%0d exp=0", held_bad4); end
    checks++; if (dut.xfer_cnt_q !== 3'd4) begin errors++; $display("FAIL alone_sat4 got=%0d exp=4", dut.xfer_cnt_q); end
    checks++; if (dut16.xfer_cnt_q !== 5'd16) begin errors++; $display("FAIL alone_sat16 got=%0d exp=16", dut16.xfer_cnt_q); end
  endtask

  task automatic test_urgent;
    int ok, other;
    do_reset(); sd_ack_en = 0;
    mire_cyc = 1; mire_stb = 1; mire_adr = MB;
    @(posedge clk); #1;
    vga_cyc = 1; vga_stb = 1; vga_adr = VB; vga_urgent = 1;
    @(negedge clk);
    checks++; if (grant !== 2'b01 || if_mire.ack !== 1'b0) begin errors++; $display("FAIL urg_stall got=%b/%b exp=01/0", grant, if_mire.ack); end
    @(posedge clk); #1 sd_ack_en = 1;
    @(negedge clk);
    checks++; if (if_mire.ack !== 1'b1 || if_sd.adr !== MB) begin errors++; $display("FAIL urg_inflight got=%b/%h exp=1/%h", if_mire.ack, if_sd.adr, MB); end
    @(posedge clk); #1 mire_adr = MB + 32'd1; vga_urgent = 0;
    @(negedge clk);
    checks++; if (grant !== 2'b00 || if_mire.ack !== 1'b0) begin errors++; $display("FAIL urg_switch got=%b/%b exp=00/0", grant, if_mire.ack); end
    @(negedge clk);
    checks++; if (grant !== 2'b10 || if_vga.ack !== 1'b1) begin errors++; $display("FAIL urg_vga got=%b/%b exp=10/1", grant, if_vga.ack); end
    @(posedge clk); #1 vga_adr = VB + 32'd1;
    @(posedge clk); #1 vga_cyc = 0; vga_stb = 0;
    ok = 0; other = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_mire.ack) begin
        if (if_sd.adr === MB + 32'd1) ok++; else other++;
      end
      @(posedge clk); #1;
      if (ok == 1) begin mire_cyc = 0; mire_stb = 0; end
    end
    checks++; if (ok !== 1 || other !== 0) begin errors++; $display("FAIL urg_resume got=%0d/%0d exp=1/0", ok, other); end
  endtask

  task automatic test_reset_mid;
    do_reset(); sd_ack_en = 1;
    mire_cyc = 1; mire_stb = 1; mire_adr = MB;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    checks++; if (if_sd.cyc !== 1'b1) begin errors++; $display("FAIL rstmid_sync got=%b exp=1", if_sd.cyc); end
    @(negedge clk);
    checks++; if (if_sd.cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rstmid_abandon got=%b/%b exp=0/00", if_sd.cyc, grant); end
    checks++; if (dut.xfer_cnt_q !== '0 || cnt_mire !== 32'd0 || cnt_vga !== 32'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d/%0d/%0d exp=0/0/0", dut.xfer_cnt_q, cnt_mire, cnt_vga); end
    idle_masters();
  endtask

  task automatic test_stats;
    int nv, nm;
    do_reset(); sd_ack_en = 1;
    vga_cyc = 1; vga_stb = 1; nv = 0;
    for (int c = 0; c < 30 && nv < 7; c++) begin
      @(negedge clk);
      if (if_vga.ack) nv++;
      @(posedge clk); #1;
      vga_adr = VB + 32'(nv);
      if (nv == 7) begin vga_cyc = 0; vga_stb = 0; end
    end
    mire_cyc = 1; mire_stb = 1; nm = 0;
    for (int c = 0; c < 30 && nm < 3; c++) begin
      @(negedge clk);
      if (if_mire.ack) nm++;
      @(posedge clk); #1;
      mire_adr = MB + 32'(nm);
      if (nm == 3) begin mire_cyc = 0; mire_stb = 0; end
    end
    @(negedge clk);
    checks++; if (cnt_vga !== EXP_V) begin errors++; $display("FAIL stats_vga got=%0d exp=%0d", cnt_vga, EXP_V); end
    checks++; if (cnt_mire !== EXP_M) begin errors++; $display("FAIL stats_mire got=%0d exp=%0d", cnt_mire, EXP_M); end
    checks++; if (cnt_vga16 !== EXP_V || cnt_mire16 !== EXP_M) begin errors++; $display("FAIL stats_q16 got=%0d/%0d exp=%0d/%0d", cnt_vga16, cnt_mire16, EXP_V, EXP_M); end
  endtask

  initial begin
    checks = 0; errors = 0;
    test_reset();
    test_both_req();
    test_quota();
    test_mire_alone();
    test_urgent();
    test_reset_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
